// File: rtl/stream_sched_pkg.sv
// Shared types and helpers for the burst scheduler.
package stream_sched_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // A programmed limit of 0 stands for the full counter range, 2^burst_w beats.
  function automatic logic [16:0] burst_limit(input logic [15:0] max_burst,
                                              input int unsigned burst_w);
    return (max_burst == 16'd0) ? (17'd1 << burst_w) : {1'b0, max_burst};
  endfunction

endpackage

// File: rtl/stream_sched_rr_pick.sv
// Round-robin picker: first requesting index at or after the rr pointer, wrapping.
module stream_sched_rr_pick #(
  parameter int unsigned N_INP = 4,
  localparam int unsigned IDX_W = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic [N_INP-1:0] req,
  input  logic [IDX_W-1:0] rr,
  output logic [IDX_W-1:0] pick,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;

  assign any_req = |req;

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = N_INP - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr) + k) % N_INP);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/stream_burst_scheduler.sv
// Burst-granular round-robin stream scheduler with synchronous flush.
// Build option STREAM_SCHED_BYPASS_EN: grant combinationally from IDLE (zero-latency arbitration).
module stream_burst_scheduler
  import stream_sched_pkg::*;
#(
  parameter type         DATA_T  = logic,
  parameter int unsigned N_INP   = 4,
  parameter int unsigned BURST_W = 4,
  localparam int unsigned IDX_W  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [BURST_W-1:0] max_burst_i,
  input  DATA_T              inp_data_i [N_INP],
  input  logic [N_INP-1:0]   inp_last_i,
  input  logic [N_INP-1:0]   inp_valid_i,
  output logic [N_INP-1:0]   inp_ready_o,
  output DATA_T              oup_data_o,
  output logic               oup_last_o,
  output logic               oup_valid_o,
  input  logic               oup_ready_i,
  output logic [IDX_W-1:0]   oup_idx_o,
  output logic               busy_o
);

  localparam int unsigned CW = BURST_W + 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BURST_W-1:0] lim_q, lim_d;

  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [CW-1:0]      lim_full;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_INP - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  stream_sched_rr_pick #(.N_INP(N_INP)) u_pick (
    .req     (inp_valid_i),
    .rr      (rr_q),
    .pick    (pick),
    .any_req (any_req)
  );

  // Counter is one bit wider than the limit so a full 2^BURST_W burst is reachable.
  assign lim_full = CW'(burst_limit(16'(lim_q), BURST_W));

`ifdef STREAM_SCHED_BYPASS_EN
  logic [CW-1:0] lim_new;
  assign lim_new = CW'(burst_limit(16'(max_burst_i), BURST_W));
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    inp_ready_o = '0;
    oup_valid_o = 1'b0;
    oup_last_o  = 1'b0;
    oup_idx_o   = '0;
    oup_data_o  = '0;
    busy_o      = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_i) begin
          rr_d  = '0;
          cnt_d = '0;
        end else if (any_req) begin
          sel_d   = pick;
          lim_d   = max_burst_i;
          cnt_d   = '0;
          state_d = LOCKED;
`ifdef STREAM_SCHED_BYPASS_EN
          oup_valid_o       = 1'b1;
          oup_data_o        = inp_data_i[pick];
          oup_idx_o         = pick;
          inp_ready_o[pick] = oup_ready_i;
          oup_last_o        = inp_last_i[pick] | (lim_new == CW'(1));
          if (oup_ready_i) begin
            if (oup_last_o) begin
              state_d = IDLE;
              rr_d    = inc_wrap(pick);
            end else begin
              cnt_d = CW'(1);
            end
          end
`endif
        end
      end

      LOCKED: begin
        busy_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
          rr_d    = '0;
          cnt_d   = '0;
        end else begin
          oup_valid_o        = inp_valid_i[sel_q];
          oup_data_o         = inp_data_i[sel_q];
          oup_idx_o          = sel_q;
          inp_ready_o[sel_q] = oup_ready_i;
          oup_last_o         = inp_valid_i[sel_q] &
                               (inp_last_i[sel_q] | (cnt_q == lim_full - CW'(1)));
          if (oup_valid_o && oup_ready_i) begin
            if (oup_last_o) begin
              state_d = IDLE;
              rr_d    = inc_wrap(sel_q);
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stream_burst_scheduler.sv
// Directed bench: a 4-input/BURST_W=4 instance and a 3-input/BURST_W=2 instance.
module tb_stream_burst_scheduler;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  // Instance A: N_INP=4, BURST_W=4
  logic       a_flush;
  logic [3:0] a_max;
  logic [7:0] a_data [4];
  logic [3:0] a_last, a_valid, a_iready;
  logic [7:0] a_odata;
  logic       a_olast, a_ovalid, a_oready, a_busy;
  logic [1:0] a_idx;

  // Instance B: N_INP=3, BURST_W=2
  logic       b_flush;
  logic [1:0] b_max;
  logic [7:0] b_data [3];
  logic [2:0] b_last, b_valid, b_iready;
  logic [7:0] b_odata;
  logic       b_olast, b_ovalid, b_oready, b_busy;
  logic [1:0] b_idx;

  int tests = 0;
  int fails = 0;

  stream_burst_scheduler #(.DATA_T(logic [7:0]), .N_INP(4), .BURST_W(4)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(a_flush), .max_burst_i(a_max),
    .inp_data_i(a_data), .inp_last_i(a_last), .inp_valid_i(a_valid), .inp_ready_o(a_iready),
    .oup_data_o(a_odata), .oup_last_o(a_olast), .oup_valid_o(a_ovalid), .oup_ready_i(a_oready),
    .oup_idx_o(a_idx), .busy_o(a_busy)
  );

  stream_burst_scheduler #(.DATA_T(logic [7:0]), .N_INP(3), .BURST_W(2)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(b_flush), .max_burst_i(b_max),
    .inp_data_i(b_data), .inp_last_i(b_last), .inp_valid_i(b_valid), .inp_ready_o(b_iready),
    .oup_data_o(b_odata), .oup_last_o(b_olast), .oup_valid_o(b_ovalid), .oup_ready_i(b_oready),
    .oup_idx_o(b_idx), .busy_o(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic l, input logic [1:0] idx,
                       input logic [3:0] rdy, input logic [7:0] d, input logic busy);
    #2;
    chk({tag, "_valid"}, 32'(a_ovalid), 32'(v));
    chk({tag, "_last"},  32'(a_olast),  32'(l));
    chk({tag, "_idx"},   32'(a_idx),    32'(idx));
    chk({tag, "_ready"}, 32'(a_iready), 32'(rdy));
    chk({tag, "_data"},  32'(a_odata),  32'(d));
    chk({tag, "_busy"},  32'(a_busy),   32'(busy));
  endtask

  task automatic chk_b(input string tag, input logic v, input logic l, input logic [1:0] idx,
                       input logic [2:0] rdy, input logic [7:0] d);
    #2;
    chk({tag, "_valid"}, 32'(b_ovalid), 32'(v));
    chk({tag, "_last"},  32'(b_olast),  32'(l));
    chk({tag, "_idx"},   32'(b_idx),    32'(idx));
    chk({tag, "_ready"}, 32'(b_iready), 32'(rdy));
    chk({tag, "_data"},  32'(b_odata),  32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i    = 1'b1;
    a_flush  = 1'b0; a_max = '0; a_last = '0; a_valid = 4'hF; a_oready = 1'b1;
    b_flush  = 1'b0; b_max = '0; b_last = '0; b_valid = '0;   b_oready = 1'b0;
    for (int i = 0; i < 4; i++) a_data[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 3; i++) b_data[i] = 8'(8'hC0 + i);
    nxt();
    chk_a("rst", 0, 0, 2'd0, 4'b0000, 8'h00, 0);
    nxt();

    // Round robin, 4-beat bursts, one bubble between bursts
    rst_i = 1'b0;
    a_max = 4'd4;
    chk_a("t1_idle0", 0, 0, 2'd0, 4'b0000, 8'h00, 0);
    nxt();
    for (int b = 0; b < 5; b++) begin
      for (int beat = 1; beat <= 4; beat++) begin
        chk_a($sformatf("t1_b%0d_beat%0d", b, beat), 1, beat == 4, 2'(b % 4),
              4'(4'd1 << (b % 4)), 8'(8'hA0 + b % 4), 1);
        nxt();
      end
      if (b == 4) a_valid = 4'b0000;
      chk_a($sformatf("t1_bubble%0d", b), 0, 0, 2'd0, 4'b0000, 8'h00, 0);
      nxt();
    end

    // Input 2 packet of 2 beats ends the burst before the limit of 8
    a_max     = 4'd8;
    a_valid   = 4'b0100;
    a_data[2] = 8'hB0;
    chk_a("t2_idle", 0, 0, 2'd0, 4'b0000, 8'h00, 0);
    nxt();
    chk_a("t2_beat1", 1, 0, 2'd2, 4'b0100, 8'hB0, 1);
    nxt();
    a_data[2] = 8'hB1;
    a_last[2] = 1'b1;
    chk_a("t2_beat2", 1, 1, 2'd2, 4'b0100, 8'hB1, 1);
    nxt();
    a_last  = '0;
    a_valid = 4'b1001;
    chk_a("t2_idle_after", 0, 0, 2'd0, 4'b0000, 8'h00, 0);
    nxt();
    chk_a("t2_rr3_beat1", 1, 0, 2'd3, 4'b1000, 8'hA3, 1);
    nxt();

    // Stall: output not ready for 5 cycles, then the remaining 7 beats
    a_oready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk_a($sformatf("t4_stall%0d", s), 1, 0, 2'd3, 4'b0000, 8'hA3, 1);
      nxt();
    end
    a_oready = 1'b1;
    for (int beat = 2; beat <= 8; beat++) begin
      chk_a($sformatf("t4_beat%0d", beat), 1, beat == 8, 2'd3, 4'b1000, 8'hA3, 1);
      nxt();
    end

    // Flush on beat 2 of input 1's burst
    a_valid = 4'b0010;
    chk_a("t5_idle", 0, 0, 2'd0, 4'b0000, 8'h00, 0);
    nxt();
    chk_a("t5_beat1", 1, 0, 2'd1, 4'b0010, 8'hA1, 1);
    nxt();
    a_flush = 1'b1;
    a_valid = 4'b1010;
    #2;
    chk("t5_flush_valid", 32'(a_ovalid), 32'd0);
    chk("t5_flush_ready", 32'(a_iready), 32'd0);
    chk("t5_flush_last",  32'(a_olast),  32'd0);
    nxt();
    a_flush = 1'b0;
    chk_a("t5_post_idle", 0, 0, 2'd0, 4'b0000, 8'h00, 0);
    nxt();
    chk_a("t5_regrant", 1, 0, 2'd1, 4'b0010, 8'hA1, 1);

    // Asynchronous reset in the middle of a burst
    rst_i = 1'b1;
    chk_a("t6_rst_now", 0, 0, 2'd0, 4'b0000, 8'h00, 0);
    nxt();
    chk_a("t6_rst_hold", 0, 0, 2'd0, 4'b0000, 8'h00, 0);
    rst_i = 1'b0;
    chk_a("t6_idle", 0, 0, 2'd0, 4'b0000, 8'h00, 0);
    nxt();
    chk_a("t6_grant", 1, 0, 2'd1, 4'b0010, 8'hA1, 1);
    a_valid = 4'b0000;

    // max_burst=0 with BURST_W=2: 4-beat bursts, single requester, 3 inputs
    b_max    = 2'd0;
    b_valid  = 3'b100;
    b_oready = 1'b1;
    chk_b("t3_idle", 0, 0, 2'd0, 3'b000, 8'h00);
    nxt();
    for (int b = 0; b < 2; b++) begin
      for (int beat = 1; beat <= 4; beat++) begin
        chk_b($sformatf("t3_b%0d_beat%0d", b, beat), 1, beat == 4, 2'd2, 3'b100, 8'hC2);
        nxt();
      end
      chk_b($sformatf("t3_bubble%0d", b), 0, 0, 2'd0, 3'b000, 8'h00);
      nxt();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
